// File: rtl/huffman_stream_encoder.sv
// Table-driven Huffman encoder: symbol stream in, MSB-first packed OUT_W-bit words out.
// Explicit flush emits the residual partial word with its bit count.
module huffman_stream_encoder #(
    parameter int unsigned SYM_W   = 8,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned OB_W    = $clog2(OUT_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               tbl_we,
    input  logic [SYM_W-1:0]   tbl_addr,
    input  logic [MAX_LEN-1:0] tbl_code,
    input  logic [LEN_W-1:0]   tbl_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SYM_W-1:0]   data_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   data_out,
    output logic [OB_W-1:0]    out_bits,
    output logic               out_last,
    output logic               flush_done,
    output logic               busy
);
    localparam int unsigned ACC_W = OUT_W + MAX_LEN;
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);
    localparam int unsigned DEPTH = 1 << SYM_W;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;

    logic [MAX_LEN-1:0] r_tbl_code [DEPTH];
    logic [LEN_W-1:0]   r_tbl_len  [DEPTH];

    logic [1:0]         r_state;
    logic               r_run_ok;
    logic               r_s1_valid;
    logic [MAX_LEN-1:0] r_s1_code;
    logic [LEN_W-1:0]   r_s1_len;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;
    logic [OB_W-1:0]    r_out_bits;
    logic               r_out_last;
    logic               r_flush_done;

    logic [1:0]         w_state_nxt;
    logic               w_flush_fin;
    logic               w_pad_load;
    logic [LEN_W-1:0]   w_wr_len;
    logic               w_drain;
    logic [CNT_W-1:0]   w_cnt_eff;
    logic [ACC_W-1:0]   w_acc_eff;
    logic               w_append;
    logic [ACC_W-1:0]   w_code_ins;
    logic               w_accept;

    // Code table: no reset, over-long lengths saturate at MAX_LEN
    assign w_wr_len = (tbl_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : tbl_len;

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            r_tbl_code[tbl_addr] <= tbl_code;
            r_tbl_len[tbl_addr]  <= w_wr_len;
        end
    end

    assign w_drain    = (r_cnt >= CNT_W'(OUT_W)) && (!r_out_valid || out_ready);
    assign w_cnt_eff  = w_drain ? (r_cnt - CNT_W'(OUT_W)) : r_cnt;
    assign w_acc_eff  = w_drain ? (r_acc << OUT_W) : r_acc;
    assign w_append   = r_s1_valid && (w_cnt_eff < CNT_W'(OUT_W));
    // Left-align the code (dropping bits above len), then slot it in after cnt_eff bits
    assign w_code_ins = (ACC_W'(r_s1_code) << (CNT_W'(ACC_W) - CNT_W'(r_s1_len))) >> w_cnt_eff;
    assign w_accept   = in_valid && in_ready;

    assign in_ready   = r_run_ok && enable && (r_state == ST_RUN) && (!r_s1_valid || w_append);
    assign out_valid  = r_out_valid;
    assign data_out   = r_out_data;
    assign out_bits   = r_out_bits;
    assign out_last   = r_out_last;
    assign flush_done = r_flush_done;
    assign busy       = r_s1_valid || (r_cnt != '0) || r_out_valid || (r_state != ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flush_fin = 1'b0;
        w_pad_load  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!r_s1_valid && (r_cnt < CNT_W'(OUT_W))) begin
                    if (r_cnt != '0) begin
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_flush_fin = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_PAD: begin
                if (!r_out_valid || out_ready) begin
                    w_pad_load  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Lookup stage, accumulator and output word register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_ok     <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_code    <= '0;
            r_s1_len     <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_bits   <= '0;
            r_out_last   <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_run_ok     <= 1'b1;
            r_flush_done <= w_pad_load || w_flush_fin;

            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_code  <= r_tbl_code[data_in];
                r_s1_len   <= r_tbl_len[data_in];
            end else if (w_append) begin
                r_s1_valid <= 1'b0;
            end

            if (w_pad_load) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_append) begin
                r_acc <= w_acc_eff | w_code_ins;
                r_cnt <= w_cnt_eff + CNT_W'(r_s1_len);
            end else begin
                r_acc <= w_acc_eff;
                r_cnt <= w_cnt_eff;
            end

            if (w_pad_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_acc[ACC_W-1 -: OUT_W];
                r_out_bits  <= OB_W'(r_cnt);
                r_out_last  <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_acc[ACC_W-1 -: OUT_W];
                r_out_bits  <= OB_W'(OUT_W);
                r_out_last  <= 1'b0;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
